// File: rtl/adder_pipe_pkg.sv
// ---------------------------------------------------------------------------
// adder_pipe_pkg
// Shared constants and helpers for the pipelined adder/subtractor.
//   DEF_WIDTH  : default operand width
//   DEF_STAGES : default number of pipeline stages (= latency)
//   slice_w()  : bits of the carry chain handled by one stage
// ---------------------------------------------------------------------------
package adder_pipe_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 2;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_pipe_slice.sv
// ---------------------------------------------------------------------------
// adder_pipe_slice
// One pipeline stage: adds slice IDX of the two operands plus the incoming
// carry, and registers the partial sum together with everything later
// stages still need.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high clear
//   en                  : advance enable (low while the output is stalled)
//   vld_i/sub_i/cin_i   : valid, subtract flag, carry from the previous stage
//   a_i/b_i             : operand A and prepared operand B (already inverted
//                         for subtract)
//   sum_i               : result bits computed by earlier stages
//   vld_o/sub_o/cout_o  : registered valid, subtract flag, carry out
//   a_o/b_o/sum_o       : registered operands and accumulated result
// ---------------------------------------------------------------------------
module adder_pipe_slice
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = slice_w(DEF_WIDTH, DEF_STAGES),
    parameter int IDX   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             vld_i,
    input  logic             sub_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    output logic             vld_o,
    output logic             sub_o,
    output logic             cout_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o
);

    // Bits of the result owned by this stage.
    localparam logic [WIDTH-1:0] SLICE_MASK =
        ({WIDTH{1'b1}} >> (WIDTH - CW)) << (IDX * CW);

    logic [CW:0]      part;
    logic             vld_d, vld_q;
    logic             sub_d, sub_q;
    logic             cout_d, cout_q;
    logic [WIDTH-1:0] a_d, a_q;
    logic [WIDTH-1:0] b_d, b_q;
    logic [WIDTH-1:0] sum_d, sum_q;

    always_comb begin
        part = {1'b0, a_i[IDX*CW +: CW]} + {1'b0, b_i[IDX*CW +: CW]}
             + {{CW{1'b0}}, cin_i};

        vld_d  = vld_q;
        sub_d  = sub_q;
        cout_d = cout_q;
        a_d    = a_q;
        b_d    = b_q;
        sum_d  = sum_q;
        if (en) begin
            vld_d  = vld_i;
            sub_d  = sub_i;
            cout_d = part[CW];
            a_d    = a_i;
            b_d    = b_i;
            // Lower slices pass through; this stage's slice is replaced.
            sum_d  = (sum_i & ~SLICE_MASK)
                   | (WIDTH'(part[CW-1:0]) << (IDX * CW));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q  <= 1'b0;
            sub_q  <= 1'b0;
            cout_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            sub_q  <= sub_d;
            cout_q <= cout_d;
            a_q    <= a_d;
            b_q    <= b_d;
            sum_q  <= sum_d;
        end
    end

    assign vld_o  = vld_q;
    assign sub_o  = sub_q;
    assign cout_o = cout_q;
    assign a_o    = a_q;
    assign b_o    = b_q;
    assign sum_o  = sum_q;

endmodule

// File: rtl/adder_pipe_n.sv
// ---------------------------------------------------------------------------
// adder_pipe_n
// Pipelined WIDTH-bit adder/subtractor; the carry chain is cut into STAGES
// equal slices, one per register stage. Ready/valid on both sides with
// full-pipeline backpressure.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   : input handshake
//   in_a, in_b, in_sub    : operands; in_sub=1 selects A-B
//   out_valid / out_ready : output handshake
//   out_sum[WIDTH-1:0]    : sum/difference
//   out_sum[WIDTH]        : carry (add) or borrow (sub)
//   out_ovf               : signed overflow of out_sum[WIDTH-1:0]
// ---------------------------------------------------------------------------
module adder_pipe_n
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_ovf
);

    localparam int CW = slice_w(WIDTH, STAGES);

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("adder_pipe_n: WIDTH must be a non-zero multiple of STAGES");
    end

    // Index k is the input of stage k; index STAGES is the output register.
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0]            sub_pipe;
    logic [STAGES:0]            cy_pipe;
    logic [STAGES:0][WIDTH-1:0] a_pipe;
    logic [STAGES:0][WIDTH-1:0] b_pipe;
    logic [STAGES:0][WIDTH-1:0] sum_pipe;

    logic             stall;
    logic             adv;
    logic [WIDTH-1:0] b_prep;

    // Subtract as A + ~B + 1: invert B and inject the 1 as carry-in.
    always_comb begin
        b_prep = in_sub ? ~in_b : in_b;
    end

    assign vld_pipe[0] = in_valid;
    assign sub_pipe[0] = in_sub;
    assign cy_pipe[0]  = in_sub;
    assign a_pipe[0]   = in_a;
    assign b_pipe[0]   = b_prep;
    assign sum_pipe[0] = '0;

    // Whole pipeline freezes while a result waits; bubbles stay in place.
    assign stall    = vld_pipe[STAGES] & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = reset | adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_slice #(
            .WIDTH (WIDTH),
            .CW    (CW),
            .IDX   (k)
        ) u_slice (
            .clock  (clock),
            .reset  (reset),
            .en     (adv),
            .vld_i  (vld_pipe[k]),
            .sub_i  (sub_pipe[k]),
            .cin_i  (cy_pipe[k]),
            .a_i    (a_pipe[k]),
            .b_i    (b_pipe[k]),
            .sum_i  (sum_pipe[k]),
            .vld_o  (vld_pipe[k+1]),
            .sub_o  (sub_pipe[k+1]),
            .cout_o (cy_pipe[k+1]),
            .a_o    (a_pipe[k+1]),
            .b_o    (b_pipe[k+1]),
            .sum_o  (sum_pipe[k+1])
        );
    end

    // Only the sign bits of the final operand copies feed the overflow flag.
    logic unused_ops;
    assign unused_ops = ^{a_pipe[STAGES][WIDTH-2:0], b_pipe[STAGES][WIDTH-2:0]};

    logic a_msb, b_msb, s_msb;
    assign a_msb = a_pipe[STAGES][WIDTH-1];
    assign b_msb = b_pipe[STAGES][WIDTH-1];
    assign s_msb = sum_pipe[STAGES][WIDTH-1];

    assign out_valid = vld_pipe[STAGES];
    // For subtract, carry-out of A+~B+1 is 1 when no borrow occurred.
    assign out_sum   = {sub_pipe[STAGES] ? ~cy_pipe[STAGES] : cy_pipe[STAGES],
                        sum_pipe[STAGES]};
    assign out_ovf   = (a_msb == b_msb) & (s_msb != a_msb);

endmodule

// File: tb/tb_adder_pipe_n.sv
module tb_adder_pipe_n;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [31:0] a, b;
    logic        sub;
    logic        v2, v4, r2, r4;
    logic        ir2, ir4, ov2, ov4, f2, f4;
    logic [32:0] s2, s4;

    adder_pipe_n #(.WIDTH(32), .STAGES(2)) u_dut2 (
        .clock(clock), .reset(reset),
        .in_valid(v2), .in_ready(ir2), .in_a(a), .in_b(b), .in_sub(sub),
        .out_valid(ov2), .out_ready(r2), .out_sum(s2), .out_ovf(f2)
    );

    adder_pipe_n #(.WIDTH(32), .STAGES(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .in_valid(v4), .in_ready(ir4), .in_a(a), .in_b(b), .in_sub(sub),
        .out_valid(ov4), .out_ready(r4), .out_sum(s4), .out_ovf(f4)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: 33-bit unsigned add/subtract; sign rules on operand/result.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic ms, output logic [32:0] rs,
                                  output logic ro);
        if (ms) rs = {1'b0, ma} - {1'b0, mb};
        else    rs = {1'b0, ma} + {1'b0, mb};
        if (ms) ro = (ma[31] != mb[31]) && (rs[31] != ma[31]);
        else    ro = (ma[31] == mb[31]) && (rs[31] != ma[31]);
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [32:0] sum;
        logic        ovf;
        string       name;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];

    task automatic set_vec(input int i, input logic [31:0] va, input logic [31:0] vb,
                           input logic vs, input logic [32:0] vsum, input logic vo,
                           input string nm);
        vecs[i].a = va; vecs[i].b = vb; vecs[i].sub = vs;
        vecs[i].sum = vsum; vecs[i].ovf = vo; vecs[i].name = nm;
    endtask

    // Single transaction on one DUT with exact latency check.
    task automatic apply(input bit sel, input vec_t v);
        int stages;
        stages = sel ? 4 : 2;
        @(posedge clock); #1;
        a = v.a; b = v.b; sub = v.sub;
        if (sel) v4 = 1'b1; else v2 = 1'b1;
        @(negedge clock);
        chk($sformatf("%s/S%0d in_ready", v.name, stages), sel ? ir4 : ir2, 1);
        @(posedge clock); #1;               // accept edge
        v2 = 1'b0; v4 = 1'b0;
        for (int k = 1; k < stages; k++) begin
            @(negedge clock);
            chk($sformatf("%s/S%0d early valid%0d", v.name, stages, k), sel ? ov4 : ov2, 0);
            @(posedge clock);
        end
        @(negedge clock);
        chk($sformatf("%s/S%0d valid", v.name, stages), sel ? ov4 : ov2, 1);
        chk($sformatf("%s/S%0d sum", v.name, stages), sel ? s4 : s2, v.sum);
        chk($sformatf("%s/S%0d ovf", v.name, stages), sel ? f4 : f2, v.ovf);
    endtask

    logic [31:0] op_a[8];
    logic [31:0] op_b[8];
    logic        op_s[8];

    task automatic set_op(input int i, input logic [31:0] oa, input logic [31:0] ob,
                          input logic os);
        op_a[i] = oa; op_b[i] = ob; op_s[i] = os;
    endtask

    // Streams n ops into the STAGES=2 DUT; out_ready low for stlen cycles
    // starting at cycle st0. Results are scoreboarded in order.
    task automatic stream(input string nm, input int n, input int st0, input int stlen);
        logic [32:0] qs[$];
        logic        qo[$];
        logic [32:0] es, prev_sum;
        logic        eo, prev_stall;
        int idx, got, cyc, last_cyc;
        idx = 0; got = 0; cyc = 0; last_cyc = 0; prev_stall = 1'b0; prev_sum = '0;
        while (got < n && cyc < 100) begin
            @(posedge clock); #1;
            r2 = !(cyc >= st0 && cyc < st0 + stlen);
            if (idx < n) begin
                a = op_a[idx]; b = op_b[idx]; sub = op_s[idx]; v2 = 1'b1;
            end else begin
                v2 = 1'b0;
            end
            @(negedge clock);
            if (v2 && ir2) begin
                model(op_a[idx], op_b[idx], op_s[idx], es, eo);
                qs.push_back(es); qo.push_back(eo);
                idx++;
            end
            if (ov2 && r2) begin
                if (qs.size() == 0) begin
                    chk($sformatf("%s unexpected result", nm), 1, 0);
                end else begin
                    chk($sformatf("%s sum[%0d]", nm, got), s2, qs.pop_front());
                    chk($sformatf("%s ovf[%0d]", nm, got), f2, qo.pop_front());
                end
                if (stlen == 0 && got > 0)
                    chk($sformatf("%s gap[%0d]", nm, got), cyc - last_cyc, 1);
                last_cyc = cyc;
                got++;
                prev_stall = 1'b0;
            end else if (ov2 && !r2) begin
                chk($sformatf("%s in_ready in stall", nm), ir2, 0);
                if (prev_stall) chk($sformatf("%s stall hold", nm), s2, prev_sum);
                prev_stall = 1'b1;
                prev_sum = s2;
            end else begin
                prev_stall = 1'b0;
            end
            cyc++;
        end
        @(posedge clock); #1;
        v2 = 1'b0; r2 = 1'b1;
        chk($sformatf("%s results delivered", nm), got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; v2 = 1'b0; v4 = 1'b0; r2 = 1'b1; r4 = 1'b1;
        a = '0; b = '0; sub = 1'b0;

        set_vec(0, 32'd3827,      32'd9273,      1'b0, 33'd13100,        1'b0, "add_small");
        set_vec(1, 32'h0FFFFFFF,  32'hFFFFFFEF,  1'b0, 33'h10FFFFFEE,    1'b0, "add_carry");
        set_vec(2, 32'h7FFFFFFF,  32'h00000001,  1'b0, 33'h080000000,    1'b1, "add_ovf");
        set_vec(3, 32'd5,         32'd7,         1'b1, 33'h1FFFFFFFE,    1'b0, "sub_borrow");
        set_vec(4, 32'h80000000,  32'h00000001,  1'b1, 33'h07FFFFFFF,    1'b1, "sub_ovf");
        set_vec(5, 32'h00000000,  32'h80000000,  1'b1, 33'h180000000,    1'b1, "sub_minneg");
        set_vec(6, 32'hFFFFFFFF,  32'h00000001,  1'b0, 33'h100000000,    1'b0, "add_wrap");
        set_vec(7, 32'h0000FFFF,  32'h00000001,  1'b0, 33'h000010000,    1'b0, "add_slicecy");
        set_vec(8, 32'h80000000,  32'h80000000,  1'b0, 33'h100000000,    1'b1, "add_negovf");
        set_vec(9, 32'd7,         32'd7,         1'b1, 33'h000000000,    1'b0, "sub_zero");

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst ov2", ov2, 0);  chk("rst ov4", ov4, 0);
        chk("rst s2", s2, 0);    chk("rst s4", s4, 0);
        chk("rst f2", f2, 0);    chk("rst f4", f4, 0);
        chk("rst ir2", ir2, 1);  chk("rst ir4", ir4, 1);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) apply(1'b0, vecs[i]);
        for (int i = 0; i < NVEC; i++) apply(1'b1, vecs[i]);

        // Back-to-back identical ops
        set_op(0, 32'd3827, 32'd9273, 1'b0);
        set_op(1, 32'd3827, 32'd9273, 1'b0);
        stream("b2b", 2, 0, 0);

        // Alternating add/sub
        for (int i = 0; i < 6; i++)
            set_op(i, 32'h10 + 32'(i * 3), 32'h13 - 32'(i), i[0]);
        stream("alt", 6, 0, 0);

        // Backpressure mid-stream
        set_op(0, 32'd1,         32'd2,         1'b0);
        set_op(1, 32'h7FFFFFFF,  32'd5,         1'b0);
        set_op(2, 32'd100,       32'd250,       1'b1);
        set_op(3, 32'hFFFF0000,  32'h0001FFFF,  1'b0);
        set_op(4, 32'h80000000,  32'd3,         1'b1);
        set_op(5, 32'd42,        32'd42,        1'b1);
        stream("bp", 6, 3, 3);

        // Reset with two ops in flight in the 4-stage pipe
        @(posedge clock); #1;
        a = 32'd3827; b = 32'd9273; sub = 1'b0; v4 = 1'b1;
        @(posedge clock); #1;
        a = 32'd5; b = 32'd7; sub = 1'b1;
        @(posedge clock); #1;
        v4 = 1'b0; reset = 1'b1;
        @(negedge clock);
        chk("s4 in_ready in reset", ir4, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("s4 flushed%0d", k), ov4, 0);
            @(posedge clock);
        end
        apply(1'b1, vecs[1]);

        // Reset while a result is stalled at the 2-stage output
        @(posedge clock); #1;
        r2 = 1'b0; a = 32'd3827; b = 32'd9273; sub = 1'b0; v2 = 1'b1;
        @(posedge clock); #1;
        a = 32'h7FFFFFFF; b = 32'd1;
        @(posedge clock); #1;
        v2 = 1'b0; reset = 1'b1;
        @(negedge clock);
        chk("s2 stalled before reset", ov2, 1);
        chk("s2 in_ready in reset", ir2, 1);
        @(posedge clock); #1;
        reset = 1'b0; r2 = 1'b1;
        @(negedge clock);
        chk("s2 post-rst valid", ov2, 0);
        chk("s2 post-rst sum", s2, 0);
        chk("s2 post-rst ovf", f2, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("s2 flushed%0d", k), ov2, 0);
        end
        apply(1'b0, vecs[4]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
